exe_mem_unit: RTL and testbench
===============================

Name: exe_mem_unit

Overview:
- Receiving end of the decoder's control interface. Consumes EXE_CMD, S, B, MEM_R_EN, MEM_W_EN and WB_EN together with operands from ID/EX.
- Executes the ALU operation, owns the NZCV status register and resolves branches.
- Runs a single outstanding data-memory transaction and presents one registered write-back result per accepted instruction.
- Upstream flow control uses a valid/ready pair; the data memory uses a req/ack pair.

Parameters:
- DATA_W, 32, datapath, address and memory-data width.
- REG_AW, 4, destination register index width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  ID/EX holds an instruction
- in_ready  out  1  unit can accept this cycle
- exe_cmd  in  4  ALU command
- s_in  in  1  update status when set
- b_in  in  1  branch instruction
- mem_r_en, mem_w_en, wb_en_in  in  1 each  decoder control bits
- val_rn, val2, val_rm  in  DATA_W each  first operand, second (pre-shifted) operand, store data
- dest_in  in  REG_AW  destination register index
- pc_in  in  DATA_W  PC+4 of the instruction
- imm24  in  24  branch offset
- status  out  4  {N,Z,C,V}
- branch_taken  out  1  one-cycle pulse
- branch_addr  out  DATA_W  branch target
- mem_req, mem_we  out  1 each  memory request, write enable
- mem_addr, mem_wdata  out  DATA_W each  memory address, write data
- mem_rdata  in  DATA_W  load data
- mem_ack  in  1  transaction complete
- wb_valid  out  1  write-back result present
- wb_en  out  1  register write enable
- wb_dest  out  REG_AW  write-back register index
- wb_value  out  DATA_W  ALU result or load data

Behaviour:
- Reset (async, low): all outputs 0, status=0000, state IDLE. in_ready=1 after reset release. Reset mid-transaction drops mem_req immediately and discards the transaction.
- Accept: in_valid & in_ready at a rising edge.
- ALU is combinational on the inputs, mod 2^DATA_W:
  - 0001 MOV: val2
  - 1001 MVN: ~val2
  - 0010 ADD: rn+val2
  - 0011 ADC: rn+val2+C
  - 0100 SUB: rn-val2
  - 0101 SBC: rn-val2-~C
  - 0110 AND, 0111 ORR, 1000 EOR: bitwise
  - Any other code: result 0.
- Flags on accept when s_in=1 and neither memory enable is set:
  - N=res[31], Z=(res==0).
  - Arithmetic ops: C=carry-out (SUB/SBC: C=NOT borrow); V=signed overflow.
  - Logic/MOV/MVN: C and V unchanged.
  - s_in is ignored for memory ops.
- ADC/SBC use the status C held before the edge.
- Branch: accept with b_in=1 sets branch_taken for exactly one cycle and branch_addr=pc_in+(sext(imm24)<<2). No writeback; wb_valid still pulses with wb_en=0.
- State machine IDLE / MEM_WAIT:
  - IDLE, accept non-memory op: cycle after accept, wb_valid=1, wb_en=wb_en_in, wb_value=ALU result, wb_dest=dest_in. Latency 1, throughput 1/cycle.
  - IDLE, accept memory op: register mem_addr=ADD result, mem_wdata=val_rm, mem_we=mem_w_en, mem_req=1 from the next cycle, then go to MEM_WAIT. in_ready=0 in MEM_WAIT.
  - MEM_WAIT: hold mem_req, mem_addr, mem_wdata and mem_we stable until mem_ack is sampled high.
  - On the ack edge: mem_req=0 and state returns to IDLE.
  - Next cycle after ack: wb_valid=1. Load: wb_en=1, wb_value=mem_rdata captured at the ack edge. Store: wb_en=0.
  - in_ready returns high the cycle after ack. No new request is issued in the ack cycle.
- mem_ack while mem_req=0 is ignored.
- wb_valid pulses are one cycle; wb_value/wb_dest hold their last value otherwise.
- Both mem_r_en and mem_w_en set: treated as a store.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- When defined: adds output align_err (1 bit, sticky, cleared only by reset). A memory op whose address has addr[1:0]!=0 raises align_err, issues no mem_req, stays in IDLE, and produces wb_valid with wb_en=0 next cycle.
- When undefined: no align_err port; the address is used unmodified.

Test Plan:
- Reset held low mid-MEM_WAIT -> mem_req=0 immediately, status=0000, in_ready=1 after release.
- SUB s_in=1, rn=5, val2=5 -> next cycle wb_value=0, status N=0 Z=1 C=1 V=0.
- ADD s_in=1, rn=0x7FFFFFFF, val2=1 -> wb_value=0x80000000, NZCV=1001. Then AND s_in=1 with result 0 -> NZCV=0101 (C, V unchanged).
- LDR rn=0x100, val2=4, mem_ack after 3 cycles with rdata=0xDEADBEEF:
  - mem_addr=0x104 stable throughout, in_ready=0.
  - wb_valid with wb_value=0xDEADBEEF one cycle after ack.
- STR followed back-to-back by ADD: ADD is not accepted until the cycle after ack. Store gives wb_en=0, ADD wb_valid follows one cycle after its accept.
- B, pc_in=0x20, imm24=0xFFFFFE -> branch_taken pulse with branch_addr=0x18, wb_en=0.

Source files
------------

// File: rtl/exe_mem_unit.sv
// exe_mem_unit: execute stage with the ALU, the NZCV register, branch resolution and one outstanding data-memory access.
// Defining MEM_ALIGN_CHECK_EN adds the sticky align_err output and suppresses misaligned memory requests.
module exe_mem_unit #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        exe_cmd,
    input  logic              s_in,
    input  logic              b_in,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic              wb_en_in,
    input  logic [DATA_W-1:0] val_rn,
    input  logic [DATA_W-1:0] val2,
    input  logic [DATA_W-1:0] val_rm,
    input  logic [REG_AW-1:0] dest_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [23:0]       imm24,
    output logic [3:0]        status,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_addr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              wb_valid,
    output logic              wb_en,
    output logic [REG_AW-1:0] wb_dest,
    output logic [DATA_W-1:0] wb_value
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic              align_err
`endif
);
    typedef enum logic {IDLE, MEM_WAIT} state_t;
    state_t state, state_nx;

    logic [DATA_W-1:0] res, op2, addr, boff;
    logic [DATA_W:0]   sum;
    logic [REG_AW-1:0] mem_dest;
    logic is_sub, use_c, arith, cin, ovf, accept, is_mem, misalign, go_mem, ack, upd_flags;

    // SUB/SBC add the inverted operand so the carry out is NOT borrow.
    assign is_sub = exe_cmd == 4'b0100 || exe_cmd == 4'b0101;
    assign use_c  = exe_cmd == 4'b0011 || exe_cmd == 4'b0101;
    assign arith  = exe_cmd == 4'b0010 || exe_cmd == 4'b0011 || is_sub;
    assign op2    = is_sub ? ~val2 : val2;
    assign cin    = use_c ? status[1] : is_sub;
    assign sum    = {1'b0, val_rn} + {1'b0, op2} + {{DATA_W{1'b0}}, cin};
    assign ovf    = (val_rn[DATA_W-1] == op2[DATA_W-1]) && (sum[DATA_W-1] != val_rn[DATA_W-1]);
    assign addr   = val_rn + val2;
    assign boff   = {{(DATA_W-26){imm24[23]}}, imm24, 2'b00};

    always_comb begin
        res = '0;
        case (exe_cmd)
            4'b0001: res = val2;
            4'b1001: res = ~val2;
            4'b0010, 4'b0011, 4'b0100, 4'b0101: res = sum[DATA_W-1:0];
            4'b0110: res = val_rn & val2;
            4'b0111: res = val_rn | val2;
            4'b1000: res = val_rn ^ val2;
            default: res = '0;
        endcase
    end

    assign in_ready  = rst && state == IDLE;
    assign accept    = in_valid && in_ready;
    assign is_mem    = mem_r_en || mem_w_en;
    assign upd_flags = s_in && !is_mem;
`ifdef MEM_ALIGN_CHECK_EN
    assign misalign  = is_mem && !b_in && addr[1:0] != 2'b00;
`else
    assign misalign  = 1'b0;
`endif
    assign go_mem    = is_mem && !b_in && !misalign;
    assign ack       = state == MEM_WAIT && mem_ack;

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= state_nx;

    always_comb begin
        state_nx = state;
        if (state == IDLE && accept && go_mem) state_nx = MEM_WAIT;
        else if (ack)                         state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status       <= '0;
            branch_taken <= 1'b0;
            branch_addr  <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_dest     <= '0;
            wb_valid     <= 1'b0;
            wb_en        <= 1'b0;
            wb_dest      <= '0;
            wb_value     <= '0;
        end else begin
            branch_taken <= 1'b0;
            wb_valid     <= 1'b0;
            if (accept) begin
                if (upd_flags)
                    status <= {res[DATA_W-1], ~|res, arith ? sum[DATA_W] : status[1], arith ? ovf : status[0]};
                if (b_in) begin
                    branch_taken <= 1'b1;
                    branch_addr  <= pc_in + boff;
                end
                if (go_mem) begin
                    mem_req   <= 1'b1;
                    mem_we    <= mem_w_en;
                    mem_addr  <= addr;
                    mem_wdata <= val_rm;
                    mem_dest  <= dest_in;
                end else begin
                    wb_valid <= 1'b1;
                    wb_en    <= wb_en_in && !b_in && !is_mem;
                    wb_dest  <= dest_in;
                    wb_value <= res;
                end
            end
            // Loads write back the data captured on the ack edge; stores only retire.
            if (ack) begin
                mem_req  <= 1'b0;
                wb_valid <= 1'b1;
                wb_en    <= !mem_we;
                wb_dest  <= mem_dest;
                if (!mem_we) wb_value <= mem_rdata;
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst)
        if (!rst)                      align_err <= 1'b0;
        else if (accept && misalign)   align_err <= 1'b1;
`endif
endmodule

// File: tb/tb_exe_mem_unit.sv
// tb_exe_mem_unit: directed stimulus with a write-back scoreboard and a memory responder that checks request stability.
module tb_exe_mem_unit;
    typedef struct {
        logic        en;
        logic [3:0]  dest;
        logic [31:0] val;
        int          when;
        bit          mem;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b0, in_valid = 1'b0, in_ready;
    logic [3:0]  exe_cmd = '0;
    logic        s_in = 1'b0, b_in = 1'b0, mem_r_en = 1'b0, mem_w_en = 1'b0, wb_en_in = 1'b0;
    logic [31:0] val_rn = '0, val2 = '0, val_rm = '0, pc_in = '0;
    logic [3:0]  dest_in = '0;
    logic [23:0] imm24 = '0;
    logic [3:0]  status;
    logic        branch_taken, mem_req, mem_we, mem_ack = 1'b0, wb_valid, wb_en;
    logic [31:0] branch_addr, mem_addr, mem_wdata, mem_rdata = '0, wb_value;
    logic [3:0]  wb_dest;

    exp_t        q[$];
    int          total = 0, bad = 0, cyc = 0, last_ack = -10, ack_delay = 3, wait_cnt = 0, acc;
    bit          hold = 1'b0;
    logic [31:0] exp_addr = '0, exp_wdata = '0, rdata = '0;
    logic        exp_we = 1'b0;

    exe_mem_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .exe_cmd(exe_cmd), .s_in(s_in), .b_in(b_in), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .wb_en_in(wb_en_in), .val_rn(val_rn), .val2(val2), .val_rm(val_rm), .dest_in(dest_in),
        .pc_in(pc_in), .imm24(imm24), .status(status), .branch_taken(branch_taken),
        .branch_addr(branch_addr), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .wb_valid(wb_valid),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic en, input logic [3:0] dest, input logic [31:0] val, input bit mem);
        exp_t e;
        e.en = en; e.dest = dest; e.val = val; e.when = 0; e.mem = mem;
        return e;
    endfunction

    task automatic issue(input logic [3:0] cmd, input logic s, b, r, w, we_in,
                         input logic [31:0] rn, v2, rm, input logic [3:0] dest,
                         input exp_t e, output int a);
        int n = 0;
        exe_cmd = cmd; s_in = s; b_in = b; mem_r_en = r; mem_w_en = w; wb_en_in = we_in;
        val_rn = rn; val2 = v2; val_rm = rm; dest_in = dest; in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("accept_timeout", in_ready, 1);
        a = cyc + 1;
        e.when = a;
        q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) check("drain_timeout", q.size(), 0);
    endtask

    // Memory responder: acks after ack_delay request cycles and checks the request is held steady.
    initial begin
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req === 1'b1 && !hold) begin
                check("mem_addr", mem_addr, exp_addr);
                check("mem_we", mem_we, exp_we);
                if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
                check("ready_in_wait", in_ready, 0);
                if (wait_cnt == ack_delay - 1) begin
                    mem_ack = 1'b1;
                    mem_rdata = rdata;
                    wait_cnt = 0;
                    last_ack = cyc + 1;
                end else wait_cnt++;
            end else wait_cnt = 0;
        end
    end

    // Write-back monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (wb_valid === 1'b1) begin
                if (q.size() == 0) check("wb_spurious", wb_valid, 0);
                else begin
                    e = q.pop_front();
                    check("wb_en", wb_en, e.en);
                    check("wb_dest", wb_dest, e.dest);
                    if (e.en) check("wb_value", wb_value, e.val);
                    check("wb_cycle", cyc, e.mem ? last_ack : e.when);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_status", status, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_branch", branch_taken, 0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_rst", in_ready, 1);

        issue(4'b0100, 1, 0, 0, 0, 1, 32'd5, 32'd5, 0, 4'd1, mk(1, 4'd1, 32'd0, 0), acc);
        check("sub_nzcv", status, 4'b0110);
        issue(4'b0011, 0, 0, 0, 0, 1, 32'd1, 32'd2, 0, 4'd2, mk(1, 4'd2, 32'd4, 0), acc);
        check("adc_nzcv_kept", status, 4'b0110);
        issue(4'b0101, 1, 0, 0, 0, 1, 32'd10, 32'd3, 0, 4'd3, mk(1, 4'd3, 32'd7, 0), acc);
        check("sbc_nzcv", status, 4'b0010);
        issue(4'b0010, 1, 0, 0, 0, 1, 32'h7FFF_FFFF, 32'd1, 0, 4'd4, mk(1, 4'd4, 32'h8000_0000, 0), acc);
        check("add_ovf_nzcv", status, 4'b1001);
        issue(4'b0110, 1, 0, 0, 0, 1, 32'hF0, 32'h0F, 0, 4'd5, mk(1, 4'd5, 32'd0, 0), acc);
        check("and_nzcv", status, 4'b0101);

        exp_addr = 32'h104; exp_we = 1'b0; rdata = 32'hDEAD_BEEF;
        issue(4'b0010, 1, 0, 1, 0, 1, 32'h100, 32'd4, 0, 4'd7, mk(1, 4'd7, 32'hDEAD_BEEF, 1), acc);
        drain();
        check("ldr_req_clear", mem_req, 0);
        check("ldr_nzcv_kept", status, 4'b0101);

        exp_addr = 32'h208; exp_we = 1'b1; exp_wdata = 32'h1234_5678;
        issue(4'b0010, 0, 0, 0, 1, 0, 32'h200, 32'd8, 32'h1234_5678, 4'd8, mk(0, 4'd8, 32'd0, 1), acc);
        issue(4'b0010, 0, 0, 0, 0, 1, 32'd3, 32'd4, 0, 4'd9, mk(1, 4'd9, 32'd7, 0), acc);
        check("add_after_str", acc, last_ack + 1);
        drain();

        pc_in = 32'h20; imm24 = 24'hFF_FFFE;
        issue(4'b0000, 0, 1, 0, 0, 1, 0, 0, 0, 4'd10, mk(0, 4'd10, 32'd0, 0), acc);
        check("br_taken", branch_taken, 1);
        check("br_addr", branch_addr, 32'h18);
        @(negedge clk);
        check("br_pulse", branch_taken, 0);

        hold = 1'b1;
        issue(4'b0010, 0, 0, 1, 0, 1, 32'h300, 32'd0, 0, 4'd11, mk(1, 4'd11, 32'd0, 1), acc);
        repeat (2) @(negedge clk);
        check("req_before_rst", mem_req, 1);
        #2 rst = 1'b0;
        #1;
        check("rst_drops_req", mem_req, 0);
        check("rst_status_clr", status, 0);
        q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        hold = 1'b0;
        @(negedge clk);
        check("ready_after_rst2", in_ready, 1);
        check("req_after_rst2", mem_req, 0);

        issue(4'b1001, 1, 0, 0, 0, 1, 0, 32'd0, 0, 4'd12, mk(1, 4'd12, 32'hFFFF_FFFF, 0), acc);
        check("mvn_nzcv", status, 4'b1000);
        drain();
        repeat (2) @(negedge clk);
        check("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
